// File: rtl/program_loader.sv
// program_loader: boot-time loader that sits in front of the 16-bit multicycle
// MIPS core. It holds the core in reset, receives a length-prefixed byte stream
// over a valid/ready handshake, packs big-endian 16-bit words into the core's
// unified memory through a dedicated write port, then releases the core.
//
// Optional build macro: PROGRAM_LOADER_CHECKSUM_EN
//   When defined, one extra byte follows the data. It must equal the XOR of all
//   data bytes, otherwise the load ends in ERROR with the core kept in reset.
//   When undefined, the last write goes straight to HOLD and no checksum
//   hardware exists.

module program_loader #(
  parameter int ADDR_W      = 5,
  parameter int WORD_W      = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Memory depth as a 9-bit value so a length byte can be compared against it
  // even when the memory holds 256 words.
  localparam logic [8:0] DEPTH_V   = 9'(1 << ADDR_W);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            state;
  state_t            next_state;

  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] last_idx;
  logic [7:0]        hi_byte;
  logic [7:0]        hold_cnt;
  logic              take;
  logic              len_bad;
  logic              last_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_acc;
`endif

  assign take      = in_valid && in_ready;
  assign len_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH_V);
  assign last_word = (counter == last_idx);

  // State register; reset returns the loader to IDLE with the core held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus all status/handshake outputs, which depend on state only.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    core_rst   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next_state = len_bad ? S_ERROR : S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next_state = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next_state = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          next_state = S_CSUM;
`else
          next_state = S_HOLD;
`endif
        end else begin
          next_state = S_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) next_state = (in_data == csum_acc) ? S_HOLD : S_ERROR;
      end
`endif
      S_HOLD: begin
        busy = 1'b1;
        if (hold_cnt == 8'd0) next_state = S_RUN;
      end
      S_RUN: begin
        core_rst = 1'b1;
        done     = 1'b1;
        if (start) next_state = S_LEN;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) next_state = S_LEN;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Word counter, length latch, byte assembly and the write-port registers.
  // The address/data are captured on the LO handshake so they are valid during
  // WRITE and then hold while the counter moves on to the next word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      counter   <= '0;
      last_idx  <= '0;
      hi_byte   <= 8'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hold_cnt  <= HOLD_INIT;
    end else begin
      if (state == S_LEN && take && !len_bad) begin
        counter  <= '0;
        last_idx <= ADDR_W'(in_data - 8'd1);
      end
      if (state == S_WRITE && !last_word) begin
        counter <= counter + 1'b1;
      end
      if (state == S_HI && take) begin
        hi_byte <= in_data;
      end
      if (state == S_LO && take) begin
        mem_addr  <= counter;
        mem_wdata <= {hi_byte, in_data};
      end
      hold_cnt <= (state == S_HOLD) ? hold_cnt - 8'd1 : HOLD_INIT;
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // Running XOR of every data byte; cleared whenever a new load is started.
  always_ff @(posedge clk) begin
    if (!rst) begin
      csum_acc <= 8'd0;
    end else if (start && (state == S_IDLE || state == S_RUN || state == S_ERROR)) begin
      csum_acc <= 8'd0;
    end else if ((state == S_HI || state == S_LO) && take) begin
      csum_acc <= csum_acc ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: self-checking bench for program_loader. A cycle-level
// vector table covers reset, the two-word load, hold timing, reload from RUN and
// length errors; hand-written sequences cover a full-depth load with gaps,
// reset in the middle of a load and (when built with PROGRAM_LOADER_CHECKSUM_EN)
// checksum accept/reject.

module tb_program_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        error;

  int assert_count = 0;
  int fail_count   = 0;
  int write_count  = 0;
  int spurious     = 0;
  bit mon_en       = 1'b0;

  logic [4:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  logic [7:0]  payload[$];

  typedef struct {
    logic        rst;
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        rdy;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        crst;
    logic        busy;
    logic        done;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  program_loader #(
    .ADDR_W(5),
    .WORD_W(16),
    .HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .core_rst(core_rst),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int r, input int s, input int v, input int d,
                         input int rd, input int we, input int a, input int w,
                         input int cr, input int b, input int dn, input int e);
    vec_t t;
    t.rst   = r[0];
    t.start = s[0];
    t.valid = v[0];
    t.data  = d[7:0];
    t.rdy   = rd[0];
    t.we    = we[0];
    t.addr  = a[4:0];
    t.wdata = w[15:0];
    t.crst  = cr[0];
    t.busy  = b[0];
    t.done  = dn[0];
    t.err   = e[0];
    vecs.push_back(t);
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    rst      = v.rst;
    start    = v.start;
    in_valid = v.valid;
    in_data  = v.data;
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d.in_ready", idx), 32'(in_ready), 32'(v.rdy));
    check_output($sformatf("vec%0d.mem_we", idx), 32'(mem_we), 32'(v.we));
    check_output($sformatf("vec%0d.mem_addr", idx), 32'(mem_addr), 32'(v.addr));
    check_output($sformatf("vec%0d.mem_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
    check_output($sformatf("vec%0d.core_rst", idx), 32'(core_rst), 32'(v.crst));
    check_output($sformatf("vec%0d.busy", idx), 32'(busy), 32'(v.busy));
    check_output($sformatf("vec%0d.done", idx), 32'(done), 32'(v.done));
    check_output($sformatf("vec%0d.error", idx), 32'(error), 32'(v.err));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one byte after an optional random gap; returns after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  took;
    gap  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    took = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 200; k++) begin
      took = in_ready;
      @(posedge clk);
      if (took) break;
      @(negedge clk);
    end
    if (!took) check_output("byteTimeout", 32'(took), 32'd1);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Start a load of payload (pairs of bytes), queueing the expected writes.
  task automatic run_load(input logic [7:0] n_byte, input logic [7:0] csum_flip, input int max_gap);
    logic [7:0] x;
    x = 8'd0;
    pulse_start();
    send_byte(n_byte, max_gap);
    for (int i = 0; i + 1 < payload.size(); i += 2) begin
      exp_addr.push_back(5'(i / 2));
      exp_data.push_back({payload[i], payload[i+1]});
      x = x ^ payload[i] ^ payload[i+1];
      send_byte(payload[i], max_gap);
      send_byte(payload[i+1], max_gap);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(x ^ csum_flip, max_gap);
`else
    if (csum_flip != 8'd0) x = 8'd0;
`endif
    idle_inputs();
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 60; k++) begin
      if (done) break;
      @(negedge clk);
    end
    check_output({name, ".done"}, 32'(done), 32'd1);
    check_output({name, ".core_rst"}, 32'(core_rst), 32'd1);
    check_output({name, ".pending"}, 32'(exp_addr.size()), 32'd0);
  endtask

  // Write-port scoreboard used by the hand-written sequences.
  always @(negedge clk) begin
    if (mon_en && mem_we) begin
      write_count++;
      check_output("readyDuringWrite", 32'(in_ready), 32'd0);
      if (exp_addr.size() == 0) begin
        spurious++;
      end else begin
        check_output("writeAddr", 32'(mem_addr), 32'(exp_addr.pop_front()));
        check_output("writeData", 32'(mem_wdata), 32'(exp_data.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    //       rst st vl data   rdy we ad wdata   cr bs dn er
    add_vec(0, 0, 0, 'h00,  0, 0, 0, 'h0000, 0, 0, 0, 0);
    add_vec(1, 0, 0, 'h00,  0, 0, 0, 'h0000, 0, 0, 0, 0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
    add_vec(1, 0, 1, 'h02,  0, 0, 0, 'h0000, 0, 0, 0, 0);
    add_vec(1, 1, 1, 'h02,  1, 0, 0, 'h0000, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h02,  1, 0, 0, 'h0000, 0, 1, 0, 0);
    add_vec(1, 1, 0, 'h12,  1, 0, 0, 'h0000, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h12,  1, 0, 0, 'h0000, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h34,  0, 1, 0, 'h1234, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'hAB,  1, 0, 0, 'h1234, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'hAB,  1, 0, 0, 'h1234, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'hCD,  0, 1, 1, 'hABCD, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add_vec(1, 0, 1, 'hCD,  0, 0, 1, 'hABCD, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'hCD,  0, 0, 1, 'hABCD, 1, 0, 1, 0);
    add_vec(1, 0, 0, 'h00,  0, 0, 1, 'hABCD, 1, 0, 1, 0);
    add_vec(1, 1, 0, 'h00,  1, 0, 1, 'hABCD, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h01,  1, 0, 1, 'hABCD, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h00,  1, 0, 1, 'hABCD, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h07,  0, 1, 0, 'h0007, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      add_vec(1, 0, 0, 'h00,  0, 0, 0, 'h0007, 0, 1, 0, 0);
    add_vec(1, 0, 0, 'h00,  0, 0, 0, 'h0007, 1, 0, 1, 0);
    add_vec(1, 1, 0, 'h00,  1, 0, 0, 'h0007, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h00,  0, 0, 0, 'h0007, 0, 0, 0, 1);
    add_vec(1, 0, 1, 'h05,  0, 0, 0, 'h0007, 0, 0, 0, 1);
    add_vec(1, 1, 0, 'h00,  1, 0, 0, 'h0007, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h21,  0, 0, 0, 'h0007, 0, 0, 0, 1);
    add_vec(1, 1, 0, 'h00,  1, 0, 0, 'h0007, 0, 1, 0, 0);
    add_vec(1, 0, 1, 'h20,  1, 0, 0, 'h0007, 0, 1, 0, 0);
    add_vec(0, 0, 0, 'h00,  0, 0, 0, 'h0000, 0, 0, 0, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    $display("[TB] full-depth load with random gaps");
    write_count = 0;
    payload.delete();
    for (int i = 0; i < 64; i++) payload.push_back(8'(i * 37 + 5));
    run_load(8'h20, 8'h00, 3);
    wait_done("fullDepth");
    check_output("fullDepth.writes", 32'(write_count), 32'd32);
    check_output("fullDepth.spurious", 32'(spurious), 32'd0);

    $display("[TB] reset in the middle of a load");
    exp_addr.push_back(5'd0);
    exp_data.push_back(16'h1122);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("midReset.in_ready", 32'(in_ready), 32'd0);
    check_output("midReset.mem_we", 32'(mem_we), 32'd0);
    check_output("midReset.mem_addr", 32'(mem_addr), 32'd0);
    check_output("midReset.mem_wdata", 32'(mem_wdata), 32'd0);
    check_output("midReset.core_rst", 32'(core_rst), 32'd0);
    check_output("midReset.busy", 32'(busy), 32'd0);
    check_output("midReset.done", 32'(done), 32'd0);
    check_output("midReset.error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    write_count = 0;
    payload.delete();
    payload.push_back(8'hBE);
    payload.push_back(8'hEF);
    run_load(8'h01, 8'h00, 1);
    wait_done("afterReset");
    check_output("afterReset.writes", 32'(write_count), 32'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    $display("[TB] checksum accept and reject");
    payload.delete();
    payload.push_back(8'h12);
    payload.push_back(8'h34);
    run_load(8'h01, 8'h00, 0);
    wait_done("csumGood");
    run_load(8'h01, 8'h01, 0);
    for (int k = 0; k < 20; k++) begin
      if (error) break;
      @(negedge clk);
    end
    check_output("csumBad.error", 32'(error), 32'd1);
    check_output("csumBad.core_rst", 32'(core_rst), 32'd0);
    check_output("csumBad.pending", 32'(exp_addr.size()), 32'd0);
`endif

    check_output("spuriousWrites", 32'(spurious), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader directly upstream of the 16-bit multicycle MIPS core.
- Holds the core in reset while a byte stream is received over a valid/ready handshake.
- Packs the bytes into 16-bit words, writes them into the core's unified instruction/data memory through a dedicated write port, then releases the core.
- Sits between the bench/host byte source and the MIPS top's memory write port and core reset input.

Parameters:
- ADDR_W, 5, memory word-address width; DEPTH = 2^ADDR_W words (32, matches the addressTest width).
- WORD_W, 16, memory word width; fixed at 16, two bytes per word.
- HOLD_CYCLES, 4, cycles core_rst stays low after the last write before release; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, RUN or ERROR.
- in_valid  input  1  byte source has a valid byte.
- in_data  input  8  byte payload.
- in_ready  output  1  loader accepts in_data this cycle.
- mem_we  output  1  memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  WORD_W  word to write.
- core_rst  output  1  reset to the MIPS core, active-low; 0 holds the core in reset.
- busy  output  1  load in progress (states LEN..HOLD).
- done  output  1  program loaded and core released.
- error  output  1  load aborted; core stays in reset.

Behaviour:
- Reset (rst=0 at clk edge) puts every output at its reset value:
  - state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - core_rst=0, busy=0, done=0, error=0.
  - Internal word counter = 0; checksum accumulator = 0.
- Reset mid-load aborts immediately. Memory already written is not cleared.
- Handshake:
  - A byte transfers on a clk edge where in_valid=1 and in_ready=1.
  - in_ready is 1 only in LEN, HI, LO (and CSUM when enabled).
  - The source holds in_data stable until the transfer.
- States:
  - IDLE: core_rst=0. start → LEN. Any in_valid is ignored.
  - LEN: the first byte is N, the word count.
    - N=0 or N>DEPTH → ERROR.
    - Otherwise latch N, clear the counter → HI.
  - HI: the byte is latched as wdata[15:8] → LO.
  - LO: the byte is latched as wdata[7:0] → WRITE. Big-endian within each word.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=counter, mem_wdata=assembled word, in_ready=0.
    - mem_we rises the cycle after the LO handshake.
    - If counter==N-1 → HOLD (or CSUM when enabled); else counter+1 → HI.
  - HOLD: core_rst=0, in_ready=0 for exactly HOLD_CYCLES cycles → RUN.
  - RUN: core_rst=1, done=1, busy=0. start → LEN; core_rst drops to 0 and done to 0 on the next edge (reload).
  - ERROR: error=1, core_rst=0, busy=0. start → LEN and clears error.
- mem_addr and mem_wdata hold their last value outside WRITE.
- mem_addr never wraps: the counter is bounded by N ≤ DEPTH. N=DEPTH writes addresses 0..DEPTH-1.
- start during LEN..HOLD is ignored. If start and in_valid arrive together in IDLE, the byte is not consumed.
- in_valid=0 stalls indefinitely in any byte state; no timeout.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, state CSUM accepts one extra byte with in_ready=1.
  - The accumulator is the XOR of every data byte (HI and LO bytes, excluding the N byte), cleared on LEN entry.
  - Match → HOLD. Mismatch → ERROR; the words are already written, but the core is not released.
- Not defined: no CSUM state; the last WRITE goes directly to HOLD and the accumulator logic is absent.

Test Plan:
- Reset then start; stream bytes 02,12,34,AB,CD with in_valid held high (in_ready gates the transfers) → mem_we pulses at addr 0 data 0x1234 and addr 1 data 0xABCD, each 1 cycle after the LO byte; core_rst rises exactly HOLD_CYCLES=4 cycles after the second WRITE; done=1.
- Stream N=00, and separately N=0x21 → error=1, no mem_we, core_rst stays 0; a later start with a valid stream recovers and clears error.
- N=32, 64 data bytes with random in_valid gaps → 32 writes, addresses 0..31 in order, no wrap; data matches; in_ready=0 during every WRITE.
- Assert rst=0 after the 3rd data byte, then release and restart with N=01,BE,EF → all outputs at reset values during reset; one write at addr 0 data 0xBEEF; done=1.
- In RUN, pulse start → core_rst=0 and done=0 next cycle; a new load with N=01,00,07 writes 0x0007 at addr 0 and re-releases the core.
- With PROGRAM_LOADER_CHECKSUM_EN: N=01,12,34 then checksum 26 → released. The same stream with checksum 27 → error=1, core_rst=0.
